// File: rtl/fetch_seq_if.sv
// fetch_seq_if: fetch control, instruction-memory and instruction-output signals of fetch_seq
// master (fetch_seq): drives mem_req/mem_addr, inst_valid/inst/inst_pc and busy; receives run,
//   mem_ready/mem_rdata, inst_accept and redirect/redirect_pc
// slave (environment): the mirror image of master
interface fetch_seq_if;
  logic        run;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_accept;
  logic        redirect;
  logic [29:0] redirect_pc;
  logic        busy;
  modport master(
    input  run, mem_ready, mem_rdata, inst_accept, redirect, redirect_pc,
    output mem_req, mem_addr, inst_valid, inst, inst_pc, busy
  );
  modport slave(
    output run, mem_ready, mem_rdata, inst_accept, redirect, redirect_pc,
    input  mem_req, mem_addr, inst_valid, inst, inst_pc, busy
  );
endinterface

// File: rtl/fetch_seq.sv
// fetch_seq: single-outstanding instruction fetch sequencer with a one-entry output buffer and redirect
// clk: clock; rst: asynchronous active-low reset; bus: fetch_seq_if master
// (run / memory request-response / instruction output handshake / redirect / busy)
module fetch_seq #(
  parameter logic [29:0] RESET_PC = 30'h0000_0000
) (
  input logic         clk,
  input logic         rst,
  fetch_seq_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;
  state_t      state_q, state_d;
  logic [29:0] pc_q, pc_d, tgt_q, tgt_d, tgt_live;
  logic [31:0] inst_q, inst_d, inst_pc_q, inst_pc_d;
  logic        valid_q, valid_d;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc_q      <= RESET_PC;
      tgt_q     <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
    end
  // a redirect arriving during DRAIN supersedes the pending target on the same edge
  assign tgt_live = bus.redirect ? bus.redirect_pc : tgt_q;
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
    case (state_q)
      IDLE:
        if (bus.redirect) pc_d = bus.redirect_pc;
        else if (bus.run) state_d = REQ;
      REQ:
        if (bus.redirect) begin
          // with a response on the same edge the data is dropped and we refetch at once;
          // otherwise pc must keep addressing the live request, so the target waits in tgt
          pc_d    = bus.mem_ready ? bus.redirect_pc : pc_q;
          tgt_d   = bus.redirect_pc;
          state_d = bus.mem_ready ? REQ : DRAIN;
        end else if (bus.mem_ready) begin
          inst_d    = bus.mem_rdata;
          inst_pc_d = {pc_q, 2'b00};
          valid_d   = 1'b1;
          pc_d      = pc_q + 30'd1;
          state_d   = HOLD;
        end
      HOLD:
        if (bus.redirect || bus.inst_accept) begin
          valid_d = 1'b0;
          pc_d    = bus.redirect ? bus.redirect_pc : pc_q;
          state_d = bus.run ? REQ : IDLE;
        end
      DRAIN: begin
        tgt_d = tgt_live;
        if (bus.mem_ready) begin
          pc_d    = tgt_live;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.mem_req    = state_q == REQ || state_q == DRAIN;
    bus.busy       = state_q != IDLE;
    bus.mem_addr   = {pc_q, 2'b00};
    bus.inst_valid = valid_q;
    bus.inst       = inst_q;
    bus.inst_pc    = inst_pc_q;
  end
endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed scenarios plus randomized traffic checked against a transaction-level fetch model
module tb_fetch_seq;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  fetch_seq_if f ();
  fetch_seq_if w ();
  fetch_seq u_dut (.clk(clk), .rst(rst), .bus(f));
  fetch_seq #(.RESET_PC(30'h3FFF_FFFF)) u_wrap (.clk(clk), .rst(rst), .bus(w));
  always #5 clk = ~clk;
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  assign f.mem_rdata = memf(f.mem_addr);
  assign w.mem_rdata = memf(w.mem_addr);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  // transaction-level model state for the random phase
  logic [29:0] nxt, raddr, epc;
  bit          outst, squash, ev, hs;
  int          deliveries;
  initial begin
    rst = 1'b0;
    f.run = 1'b1; f.mem_ready = 1'b0; f.inst_accept = 1'b0; f.redirect = 1'b0; f.redirect_pc = '0;
    w.run = 1'b0; w.mem_ready = 1'b0; w.inst_accept = 1'b0; w.redirect = 1'b0; w.redirect_pc = '0;
    repeat (2) tick;
    chk("rst_req", f.mem_req, 0);
    chk("rst_addr", f.mem_addr, 0);
    chk("rst_valid", f.inst_valid, 0);
    chk("rst_inst", f.inst, 0);
    chk("rst_inst_pc", f.inst_pc, 0);
    chk("rst_busy", f.busy, 0);
    chk("rst_wrap_addr", w.mem_addr, 32'hFFFF_FFFC);
    rst = 1'b1;
    f.run = 1'b0;
    tick;
    chk("idle_no_run_req", f.mem_req, 0);
    chk("idle_no_run_busy", f.busy, 0);
    // zero-wait sequential fetch
    f.run = 1'b1; f.mem_ready = 1'b1; f.inst_accept = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("zw_req", f.mem_req, 1);
      chk("zw_addr", f.mem_addr, 32'(4 * k));
      chk("zw_not_yet_valid", f.inst_valid, 0);
      tick;
      chk("zw_valid", f.inst_valid, 1);
      chk("zw_inst_pc", f.inst_pc, 32'(4 * k));
      chk("zw_inst", f.inst, memf(32'(4 * k)));
      chk("zw_hold_noreq", f.mem_req, 0);
    end
    f.run = 1'b0;
    tick;
    chk("stop_busy", f.busy, 0);
    chk("stop_req", f.mem_req, 0);
    // wait states: request held for four cycles, valid one cycle after ready
    f.run = 1'b1; f.mem_ready = 1'b0; f.inst_accept = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("ws_req", f.mem_req, 1);
      chk("ws_addr", f.mem_addr, 32'h0C);
      chk("ws_valid", f.inst_valid, 0);
    end
    f.mem_ready = 1'b1;
    tick;
    chk("ws_valid_rise", f.inst_valid, 1);
    chk("ws_inst_pc", f.inst_pc, 32'h0C);
    chk("ws_inst", f.inst, memf(32'h0C));
    // backpressure
    f.mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", f.inst_valid, 1);
      chk("bp_inst", f.inst, memf(32'h0C));
      chk("bp_inst_pc", f.inst_pc, 32'h0C);
      chk("bp_noreq", f.mem_req, 0);
      tick;
    end
    f.inst_accept = 1'b1;
    tick;
    f.inst_accept = 1'b0;
    chk("bp_next_req", f.mem_req, 1);
    chk("bp_next_addr", f.mem_addr, 32'h10);
    chk("bp_cleared", f.inst_valid, 0);
    // redirect with response on the same edge, then redirects while draining
    f.mem_ready = 1'b1; f.redirect = 1'b1; f.redirect_pc = 30'h2;
    tick;
    chk("rr_req", f.mem_req, 1);
    chk("rr_addr", f.mem_addr, 32'h8);
    chk("rr_dropped", f.inst_valid, 0);
    f.mem_ready = 1'b0; f.redirect_pc = 30'h100;
    tick;
    chk("dr_req", f.mem_req, 1);
    chk("dr_old_addr", f.mem_addr, 32'h8);
    f.redirect_pc = 30'h200;
    tick;
    chk("dr_old_addr2", f.mem_addr, 32'h8);
    chk("dr_no_inst", f.inst_valid, 0);
    f.redirect = 1'b0; f.mem_ready = 1'b1;
    tick;
    chk("dr_new_req", f.mem_req, 1);
    chk("dr_new_addr", f.mem_addr, 32'h800);
    chk("dr_dropped", f.inst_valid, 0);
    tick;
    chk("dr_valid", f.inst_valid, 1);
    chk("dr_inst_pc", f.inst_pc, 32'h800);
    chk("dr_inst", f.inst, memf(32'h800));
    f.inst_accept = 1'b1; f.run = 1'b0; f.mem_ready = 1'b0;
    tick;
    chk("dr_idle", f.busy, 0);
    f.inst_accept = 1'b0;
    // reset in the middle of a request, late response afterwards
    f.run = 1'b1;
    tick;
    chk("mr_req", f.mem_req, 1);
    chk("mr_addr", f.mem_addr, 32'h804);
    rst = 1'b0;
    #1;
    chk("mr_async_req", f.mem_req, 0);
    chk("mr_async_addr", f.mem_addr, 0);
    chk("mr_async_busy", f.busy, 0);
    tick;
    rst = 1'b1; f.run = 1'b0; f.mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick;
      chk("mr_valid", f.inst_valid, 0);
      chk("mr_req_after", f.mem_req, 0);
      chk("mr_busy", f.busy, 0);
      chk("mr_inst", f.inst, 0);
      chk("mr_inst_pc", f.inst_pc, 0);
    end
    f.mem_ready = 1'b0;
    // 30-bit pc wrap
    w.run = 1'b1; w.mem_ready = 1'b1; w.inst_accept = 1'b1;
    tick;
    chk("wrap_addr_top", w.mem_addr, 32'hFFFF_FFFC);
    tick;
    chk("wrap_inst_pc_top", w.inst_pc, 32'hFFFF_FFFC);
    chk("wrap_inst_top", w.inst, memf(32'hFFFF_FFFC));
    tick;
    chk("wrap_addr_zero", w.mem_addr, 32'h0);
    tick;
    chk("wrap_inst_pc_zero", w.inst_pc, 32'h0);
    w.run = 1'b0;
    // randomized traffic against the model
    rst = 1'b0;
    outst = 0; squash = 0; ev = 0; nxt = 30'h0; raddr = '0; epc = '0; deliveries = 0;
    tick;
    rst = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      chk("rnd_valid", f.inst_valid, ev);
      if (ev) begin
        chk("rnd_inst_pc", f.inst_pc, {epc, 2'b00});
        chk("rnd_inst", f.inst, memf({epc, 2'b00}));
        chk("rnd_hold_noreq", f.mem_req, 0);
      end
      if (f.mem_req) begin
        if (!outst) begin
          chk("rnd_req_addr", f.mem_addr, {nxt, 2'b00});
          outst = 1; raddr = nxt; squash = 0;
        end else chk("rnd_req_stable", f.mem_addr, {raddr, 2'b00});
      end else chk("rnd_req_retracted", outst, 0);
      chk("rnd_busy", f.busy, f.mem_req | f.inst_valid);
      rst           = 1'b1;
      f.run         = $urandom_range(0, 9) != 0;
      f.mem_ready   = $urandom_range(0, 2) == 0;
      f.inst_accept = $urandom_range(0, 1) == 1;
      f.redirect    = $urandom_range(0, 11) == 0;
      f.redirect_pc = $urandom_range(0, 3) == 0 ? 30'h3FFF_FFFF : 30'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b0;
        outst = 0; squash = 0; ev = 0; nxt = 30'h0;
      end else begin
        hs = f.mem_req && f.mem_ready;
        if (ev && f.inst_accept) deliveries++;
        if (f.redirect) begin
          ev = 0;
          nxt = f.redirect_pc;
          if (outst && !hs) squash = 1;
        end else begin
          if (f.inst_accept) ev = 0;
          if (hs && !squash) begin
            ev = 1; epc = raddr; nxt = raddr + 30'd1;
          end
        end
        if (hs) begin
          outst = 0; squash = 0;
        end
      end
      tick;
    end
    chk("rnd_progress", deliveries > 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Parameter RESET_PC, default 30'h0000_0000, SHALL be the word address (byte address >> 2) loaded into the PC on reset.
REQ-002 clk  in  1  SHALL be the clock; all state changes occur on its rising edge.
REQ-003 rst  in  1  SHALL be the reset: asynchronous, active-low.
REQ-004 run  in  1  SHALL be the level fetch enable: 1 = keep fetching, 0 = stop at the next instruction boundary.
REQ-005 mem_req  out  1  SHALL be the instruction-memory request.
REQ-006 mem_addr  out  32  SHALL be the request byte address, equal to {pc, 2'b00}.
REQ-007 mem_ready  in  1  SHALL be the memory response strobe, sampled only while mem_req=1.
REQ-008 mem_rdata  in  32  SHALL be the instruction word, valid when mem_ready=1.
REQ-009 inst_valid  out  1  SHALL indicate that the inst/inst_pc outputs hold a fetched instruction.
REQ-010 inst  out  32  SHALL be the held instruction word.
REQ-011 inst_pc  out  32  SHALL be the byte address of inst.
REQ-012 inst_accept  in  1  SHALL be the consumer-ready signal; a transfer completes when inst_valid=1 and inst_accept=1 on the same edge.
REQ-013 redirect  in  1  SHALL request a branch or jump redirect.
REQ-014 redirect_pc  in  30  SHALL be the word-address redirect target.
REQ-015 busy  out  1  SHALL be 1 whenever the state is not IDLE.

Function
REQ-016 The block SHALL implement four states: IDLE, REQ, HOLD and DRAIN.
REQ-017 At most one memory request SHALL be outstanding at any time.
REQ-018 The block SHALL hold a one-entry output buffer (inst, inst_pc).
REQ-019 IDLE with run=1 SHALL go to REQ; mem_req SHALL rise the cycle after run is sampled high.
REQ-020 In REQ, mem_req=1 and mem_addr SHALL remain stable until mem_ready=1 is sampled.
REQ-021 In REQ, mem_ready=1 with redirect=0 SHALL, on that edge:
- capture inst <= mem_rdata and inst_pc <= mem_addr;
- set inst_valid <= 1 and pc <= pc+1;
- go to HOLD.
REQ-022 inst_valid SHALL rise the cycle after mem_ready, so minimum start-to-valid latency is 2 cycles with zero-wait memory.
REQ-023 In HOLD, mem_req SHALL be 0, and inst/inst_pc SHALL be stable until the transfer completes.
REQ-024 In HOLD, inst_accept=1 SHALL clear inst_valid, then go to REQ if run=1, else to IDLE.
REQ-025 In HOLD, inst_accept=0 SHALL keep the state in HOLD, independent of run.
REQ-026 Redirect in IDLE SHALL load pc <= redirect_pc and remain in IDLE.
REQ-027 Redirect in HOLD SHALL load pc <= redirect_pc, clear inst_valid and go to REQ (or to IDLE if run=0).
- With inst_accept=1 on the same edge, the transfer counts as completed.
- With inst_accept=0, the held instruction is squashed.
REQ-028 Redirect in REQ with mem_ready=1 on the same edge SHALL discard mem_rdata, leave inst_valid at 0, load pc <= redirect_pc and stay in REQ.
REQ-029 Redirect in REQ with mem_ready=0 SHALL load pc_next <= redirect_pc and go to DRAIN.
REQ-030 In DRAIN, mem_req SHALL stay 1 at the old address (a request is never retracted).
- On mem_ready, the data is discarded and the block goes to REQ at the new pc.
REQ-031 Redirect during DRAIN SHALL overwrite the pending target; the newest target wins.
REQ-032 The run input SHALL NOT abort REQ or DRAIN; those states always complete.
REQ-033 PC increment SHALL be 30-bit modulo: 30'h3FFF_FFFF + 1 = 0.
REQ-034 mem_addr[1:0] and inst_pc[1:0] SHALL always be 2'b00.
REQ-035 No instruction SHALL ever be presented from a squashed or discarded fetch.

Reset
REQ-036 While rst=0, the block SHALL immediately force:
- state = IDLE, pc = RESET_PC;
- mem_req = 0, mem_addr = {RESET_PC, 2'b00};
- inst_valid = 0, inst = 0, inst_pc = 0, busy = 0.
REQ-037 Assertion of rst mid-transaction SHALL abandon any outstanding request; a late mem_ready after reset release SHALL be ignored (mem_req=0).
REQ-038 The first fetch after reset release SHALL occur only once run=1, at RESET_PC.

Verification
REQ-039 Zero-wait sequential fetch: run=1, mem_ready tied to 1, inst_accept=1 -> addresses 0x0, 0x4, 0x8 are fetched in order, with inst_pc matching each inst.
REQ-040 Wait states: mem_ready delayed 3 cycles -> mem_addr stays stable for 4 cycles and inst_valid rises exactly 1 cycle after mem_ready.
REQ-041 Backpressure: inst_accept=0 for 5 cycles -> inst held constant and mem_req=0 throughout; the next fetch address is inst_pc+4.
REQ-042 Redirect in DRAIN: redirect to 30'h100 while waiting on 0x8, with a second redirect to 30'h200 before mem_ready -> the 0x8 data is dropped, the next request is 0x800 and no instruction from 0x8 or 0x400 ever appears.
REQ-043 Wrap: RESET_PC=30'h3FFF_FFFF -> fetch 0xFFFF_FFFC followed by 0x0000_0000.
REQ-044 Mid-flight reset: rst=0 during REQ, then mem_ready pulses after release with run=0 -> all outputs are at reset values, inst_valid stays 0 and the block stays IDLE.
